// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed 7-segment bus.
//   - Bit positions of segments a..g and dp on the 8-bit segment bus.
//   - The 16 hex glyph patterns (abcdefg order, 1 = lit). The display
//     driver uses the same constants.
//   - decode_segments(): abcdefg pattern -> {legal, nibble}.
package seven_segment_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [6:0] PAT_0 = 7'b1111110;
    localparam logic [6:0] PAT_1 = 7'b0110000;
    localparam logic [6:0] PAT_2 = 7'b1101101;
    localparam logic [6:0] PAT_3 = 7'b1111001;
    localparam logic [6:0] PAT_4 = 7'b0110011;
    localparam logic [6:0] PAT_5 = 7'b1011011;
    localparam logic [6:0] PAT_6 = 7'b1011111;
    localparam logic [6:0] PAT_7 = 7'b1110000;
    localparam logic [6:0] PAT_8 = 7'b1111111;
    localparam logic [6:0] PAT_9 = 7'b1111011;
    localparam logic [6:0] PAT_A = 7'b1110111;
    localparam logic [6:0] PAT_B = 7'b0011111;
    localparam logic [6:0] PAT_C = 7'b1001110;
    localparam logic [6:0] PAT_D = 7'b0111101;
    localparam logic [6:0] PAT_E = 7'b1001111;
    localparam logic [6:0] PAT_F = 7'b1000111;

    // Returns {legal, nibble}. Anything outside the glyph table (blank
    // included) decodes to {0, 4'h0}.
    function automatic logic [4:0] decode_segments(input logic [6:0] abcdefg);
        logic [4:0] result;
        result = 5'b0_0000;
        case (abcdefg)
            PAT_0:   result = {1'b1, 4'h0};
            PAT_1:   result = {1'b1, 4'h1};
            PAT_2:   result = {1'b1, 4'h2};
            PAT_3:   result = {1'b1, 4'h3};
            PAT_4:   result = {1'b1, 4'h4};
            PAT_5:   result = {1'b1, 4'h5};
            PAT_6:   result = {1'b1, 4'h6};
            PAT_7:   result = {1'b1, 4'h7};
            PAT_8:   result = {1'b1, 4'h8};
            PAT_9:   result = {1'b1, 4'h9};
            PAT_A:   result = {1'b1, 4'hA};
            PAT_B:   result = {1'b1, 4'hB};
            PAT_C:   result = {1'b1, 4'hC};
            PAT_D:   result = {1'b1, 4'hD};
            PAT_E:   result = {1'b1, 4'hE};
            PAT_F:   result = {1'b1, 4'hF};
            default: result = 5'b0_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational decode of one 8-bit segment-bus pattern.
//   pattern : a..g on bits 7..1, dp on bit 0
//   legal   : pattern is one of the 16 hex glyphs
//   nibble  : decoded hex value (0 when not legal)
//   dp      : decimal point, passed through regardless of legality
module seven_segment_pattern_decoder
    import seven_segment_pkg::*;
(
    input  logic [7:0] pattern,
    output logic       legal,
    output logic [3:0] nibble,
    output logic       dp
);

    logic [4:0] decoded;

    assign decoded = decode_segments(pattern[SEG_A:SEG_G]);
    assign legal   = decoded[4];
    assign nibble  = decoded[3:0];
    assign dp      = pattern[SEG_DP];

endmodule

// File: rtl/seven_segment_bus_decoder.sv
// Receiver for a multiplexed 7-segment bus. Registers the segment and
// digit-select buses, waits for each scan slot to settle, decodes the
// glyph into a shadow frame and publishes the frame when the scan wraps
// back to a lower-or-equal digit or the bus has been idle long enough.
//   clk, reset_n           : clock, synchronous active-low reset
//   display_led_segments   : a..g on 7..1, dp on 0
//   display_segment_enable : one-hot digit select
//   data / digit_valid / decimal_point / pattern_error : published frame
//   frame_valid            : one-cycle pulse when the frame outputs update
//   select_error           : multi-hot select seen since last publication
module seven_segment_bus_decoder
    import seven_segment_pkg::*;
#(
    parameter int WIDTH_NIBBLES = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int IDLE_TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 display_led_segments,
    input  logic [WIDTH_NIBBLES-1:0]   display_segment_enable,
    output logic [4*WIDTH_NIBBLES-1:0] data,
    output logic [WIDTH_NIBBLES-1:0]   digit_valid,
    output logic [WIDTH_NIBBLES-1:0]   decimal_point,
    output logic [WIDTH_NIBBLES-1:0]   pattern_error,
    output logic                       frame_valid,
    output logic                       select_error
);

    localparam int W      = WIDTH_NIBBLES;
    localparam int IDX_W  = (W > 1) ? $clog2(W) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [7:0]        SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [W-1:0]      SEL_ONE    = W'(1);

    // Input stage and its one-cycle-old copy used for change detection.
    logic [7:0]        seg_reg, seg_prev_reg;
    logic [W-1:0]      sel_reg, sel_prev_reg;

    logic [7:0]        settle_cnt_reg, settle_cnt_next;
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic              slot_done_reg, slot_done_next;
    logic [IDX_W-1:0]  last_idx_reg;

    logic              bus_changed, sel_changed;
    logic              sel_one_hot, sel_multi_hot;
    logic [IDX_W-1:0]  sel_idx;
    logic              capture_en, frame_wrap, timeout_pub, publish;

    logic              dec_legal, dec_dp;
    logic [3:0]        dec_nibble;

    logic [4*W-1:0]    shadow_data;
    logic [W-1:0]      shadow_valid, shadow_err, shadow_dp, shadow_cap;
    logic              shadow_any;

    seven_segment_pattern_decoder u_pattern_decoder (
        .pattern (seg_reg),
        .legal   (dec_legal),
        .nibble  (dec_nibble),
        .dp      (dec_dp)
    );

    always_comb begin
        bus_changed   = (seg_reg != seg_prev_reg) || (sel_reg != sel_prev_reg);
        sel_changed   = (sel_reg != sel_prev_reg);
        sel_one_hot   = (sel_reg != '0) && ((sel_reg & (sel_reg - SEL_ONE)) == '0);
        sel_multi_hot = (sel_reg != '0) && !sel_one_hot;

        sel_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (sel_reg[i]) begin
                sel_idx = IDX_W'(i);
            end
        end

        if (bus_changed) begin
            settle_cnt_next = 8'd0;
        end else if (settle_cnt_reg == SETTLE_MAX) begin
            settle_cnt_next = SETTLE_MAX;
        end else begin
            settle_cnt_next = settle_cnt_reg + 8'd1;
        end

        if (sel_reg != '0) begin
            idle_cnt_next = '0;
        end else if (idle_cnt_reg == IDLE_MAX) begin
            idle_cnt_next = IDLE_MAX;
        end else begin
            idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end

        shadow_any = (shadow_cap != '0);

        // A change of select already forces settle_cnt_next to 0, so a
        // stale slot_done_reg can never block the first capture of a slot.
        capture_en  = (settle_cnt_next == SETTLE_MAX) && sel_one_hot && !slot_done_reg;
        frame_wrap  = capture_en && shadow_any && (sel_idx <= last_idx_reg);
        timeout_pub = (sel_reg == '0) && (idle_cnt_next == IDLE_MAX) && shadow_any;
        publish     = frame_wrap || timeout_pub;

        if (sel_changed) begin
            slot_done_next = 1'b0;
        end else if (capture_en) begin
            slot_done_next = 1'b1;
        end else begin
            slot_done_next = slot_done_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_reg        <= '0;
            seg_prev_reg   <= '0;
            sel_reg        <= '0;
            sel_prev_reg   <= '0;
            settle_cnt_reg <= '0;
            idle_cnt_reg   <= '0;
            slot_done_reg  <= 1'b0;
            last_idx_reg   <= '0;
        end else begin
            seg_reg        <= display_led_segments;
            seg_prev_reg   <= seg_reg;
            sel_reg        <= display_segment_enable;
            sel_prev_reg   <= sel_reg;
            settle_cnt_reg <= settle_cnt_next;
            idle_cnt_reg   <= idle_cnt_next;
            slot_done_reg  <= slot_done_next;
            if (capture_en) begin
                last_idx_reg <= sel_idx;
            end
        end
    end

    // Per-digit shadow slot. On a wrap the current capture wins over the
    // clear, so it becomes the first digit of the new frame.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_shadow
            logic [3:0] nibble_reg;
            logic       valid_reg, err_reg, dp_reg, cap_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    nibble_reg <= '0;
                    valid_reg  <= 1'b0;
                    err_reg    <= 1'b0;
                    dp_reg     <= 1'b0;
                    cap_reg    <= 1'b0;
                end else if (capture_en && (sel_idx == IDX_W'(gi))) begin
                    nibble_reg <= dec_nibble;
                    valid_reg  <= dec_legal;
                    err_reg    <= !dec_legal;
                    dp_reg     <= dec_dp;
                    cap_reg    <= 1'b1;
                end else if (publish) begin
                    nibble_reg <= '0;
                    valid_reg  <= 1'b0;
                    err_reg    <= 1'b0;
                    dp_reg     <= 1'b0;
                    cap_reg    <= 1'b0;
                end
            end

            assign shadow_data[4*gi +: 4] = nibble_reg;
            assign shadow_valid[gi]       = valid_reg;
            assign shadow_err[gi]         = err_reg;
            assign shadow_dp[gi]          = dp_reg;
            assign shadow_cap[gi]         = cap_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data          <= '0;
            digit_valid   <= '0;
            decimal_point <= '0;
            pattern_error <= '0;
            frame_valid   <= 1'b0;
            select_error  <= 1'b0;
        end else begin
            frame_valid <= publish;
            if (publish) begin
                data          <= shadow_data;
                digit_valid   <= shadow_valid;
                decimal_point <= shadow_dp;
                pattern_error <= shadow_err;
                select_error  <= sel_multi_hot;
            end else begin
                select_error  <= select_error | sel_multi_hot;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_bus_decoder.sv
module tb_seven_segment_bus_decoder;

    localparam int W    = 6;
    localparam int S    = 4;
    localparam int IDLE = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    segs;
    logic [W-1:0]  sel;
    logic [4*W-1:0] data;
    logic [W-1:0]  digit_valid, decimal_point, pattern_error;
    logic          frame_valid, select_error;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int fv_b2b   = 0;
    logic fv_prev = 1'b0;
    int fv_base;

    seven_segment_bus_decoder #(
        .WIDTH_NIBBLES (W),
        .SETTLE_CYCLES (S),
        .IDLE_TIMEOUT  (IDLE)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .display_led_segments   (segs),
        .display_segment_enable (sel),
        .data                   (data),
        .digit_valid            (digit_valid),
        .decimal_point          (decimal_point),
        .pattern_error          (pattern_error),
        .frame_valid            (frame_valid),
        .select_error           (select_error)
    );

    always #5 clk = ~clk;

    // Count frame_valid pulses and flag any two in a row.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_cnt <= fv_cnt + 1;
            if (fv_prev) fv_b2b <= fv_b2b + 1;
        end
        fv_prev <= (frame_valid === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Hand-written glyph table, abcdefg.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One blank cycle, then hold digit k with pattern p.
    task automatic drive_digit(input int k, input logic [7:0] p, input int hold);
        sel  = '0;
        segs = '0;
        tick(1);
        sel  = W'(1) << k;
        segs = p;
        tick(hold);
    endtask

    task automatic scan(input logic [23:0] d, input logic [5:0] en, input logic [5:0] dpv);
        for (int k = 0; k < W; k++) begin
            if (en[k]) drive_digit(k, {glyph(d[4*k +: 4]), dpv[k]}, 8);
        end
    endtask

    task automatic go_idle(input int n);
        sel  = '0;
        segs = '0;
        tick(n);
    endtask

    initial begin
        reset_n = 1'b0;
        sel     = '0;
        segs    = '0;
        tick(3);
        check_eq("reset_data",          32'(data),          32'h0);
        check_eq("reset_digit_valid",   32'(digit_valid),   32'h0);
        check_eq("reset_decimal_point", 32'(decimal_point), 32'h0);
        check_eq("reset_pattern_error", 32'(pattern_error), 32'h0);
        check_eq("reset_frame_valid",   32'(frame_valid),   32'h0);
        check_eq("reset_select_error",  32'(select_error),  32'h0);
        reset_n = 1'b1;
        tick(2);

        // Loopback of a full frame, second publication on the next wrap.
        fv_base = fv_cnt;
        scan(24'h1A2B3C, 6'h3F, 6'h00);
        scan(24'h1A2B3C, 6'h3F, 6'h00);
        drive_digit(0, {glyph(4'hC), 1'b0}, 8);
        check_eq("loop_frames",        32'(fv_cnt - fv_base), 32'd2);
        check_eq("loop_data",          32'(data),             32'h1A2B3C);
        check_eq("loop_digit_valid",   32'(digit_valid),      32'h3F);
        check_eq("loop_pattern_error", 32'(pattern_error),    32'h0);
        check_eq("loop_select_error",  32'(select_error),     32'h0);

        // Blanked digit 3, dp on digit 1.
        fv_base = fv_cnt;
        scan(24'h1A2B3C, 6'b110111, 6'b000010);
        drive_digit(0, {glyph(4'hC), 1'b0}, 8);
        check_eq("blank_frames",        32'(fv_cnt - fv_base), 32'd2);
        check_eq("blank_data",          32'(data),             32'h1A0B3C);
        check_eq("blank_digit_valid",   32'(digit_valid),      32'b110111);
        check_eq("blank_decimal_point", 32'(decimal_point),    32'b000010);
        check_eq("blank_pattern_error", 32'(pattern_error),    32'h0);

        // Glitch on digit 2 after it was captured: slot must not recapture.
        fv_base = fv_cnt;
        drive_digit(2, {glyph(4'h5), 1'b0}, 8);
        segs = {glyph(4'h8), 1'b1};
        tick(2);
        segs = {glyph(4'h5), 1'b0};
        tick(8);
        go_idle(IDLE + 4);
        check_eq("glitch_frames",        32'(fv_cnt - fv_base), 32'd1);
        check_eq("glitch_data",          32'(data),             32'h00050C);
        check_eq("glitch_digit_valid",   32'(digit_valid),      32'b000101);
        check_eq("glitch_pattern_error", 32'(pattern_error),    32'h0);

        // Illegal pattern (segment g only) on digit 0.
        fv_base = fv_cnt;
        drive_digit(0, 8'b00000010, 8);
        go_idle(IDLE + 4);
        check_eq("illegal_frames",        32'(fv_cnt - fv_base), 32'd1);
        check_eq("illegal_pattern_error", 32'(pattern_error),    32'b000001);
        check_eq("illegal_digit_valid",   32'(digit_valid),      32'h0);
        check_eq("illegal_data",          32'(data),             32'h0);

        // Timeout after digits 3..5, then multi-hot select.
        fv_base = fv_cnt;
        drive_digit(3, {glyph(4'h7), 1'b0}, 8);
        drive_digit(4, {glyph(4'h8), 1'b1}, 8);
        drive_digit(5, {glyph(4'h9), 1'b0}, 8);
        go_idle(IDLE - 2);
        check_eq("timeout_early",        32'(fv_cnt - fv_base), 32'd0);
        tick(6);
        check_eq("timeout_frames",       32'(fv_cnt - fv_base), 32'd1);
        check_eq("timeout_digit_valid",  32'(digit_valid),      32'b111000);
        check_eq("timeout_data",         32'(data),             32'h987000);
        check_eq("timeout_decimal_point", 32'(decimal_point),   32'b010000);
        check_eq("timeout_select_error", 32'(select_error),     32'h0);
        sel  = 6'b000011;
        segs = {glyph(4'h3), 1'b0};
        tick(8);
        check_eq("multihot_select_error", 32'(select_error),     32'h1);
        check_eq("multihot_no_frame",     32'(fv_cnt - fv_base), 32'd1);
        drive_digit(0, {glyph(4'h1), 1'b0}, 8);
        drive_digit(1, {glyph(4'h2), 1'b0}, 8);
        check_eq("multihot_sticky",       32'(select_error),     32'h1);
        go_idle(IDLE + 4);
        check_eq("multihot_frames",       32'(fv_cnt - fv_base), 32'd2);
        check_eq("multihot_cleared",      32'(select_error),     32'h0);
        check_eq("multihot_data",         32'(data),             32'h000021);
        check_eq("multihot_digit_valid",  32'(digit_valid),      32'b000011);

        // Reset in the middle of a frame.
        fv_base = fv_cnt;
        drive_digit(0, {glyph(4'h4), 1'b0}, 8);
        drive_digit(1, {glyph(4'h5), 1'b0}, 8);
        drive_digit(2, {glyph(4'h6), 1'b0}, 8);
        sel     = '0;
        segs    = '0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check_eq("midreset_data",          32'(data),             32'h0);
        check_eq("midreset_digit_valid",   32'(digit_valid),      32'h0);
        check_eq("midreset_pattern_error", 32'(pattern_error),    32'h0);
        check_eq("midreset_decimal_point", 32'(decimal_point),    32'h0);
        check_eq("midreset_no_frame",      32'(fv_cnt - fv_base), 32'd0);
        scan(24'hFEDCBA, 6'h3F, 6'h00);
        check_eq("midreset_no_spurious",   32'(fv_cnt - fv_base), 32'd0);
        drive_digit(0, {glyph(4'hA), 1'b0}, 8);
        check_eq("midreset_frames",        32'(fv_cnt - fv_base), 32'd1);
        check_eq("midreset_new_data",      32'(data),             32'hFEDCBA);
        check_eq("midreset_new_valid",     32'(digit_valid),      32'h3F);

        check_eq("frame_valid_back_to_back", 32'(fv_b2b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_bus_decoder.md
Name: seven_segment_bus_decoder

Overview:
Receive side of the multiplexed 7-segment bus produced by our display driver. It samples the segment bus and the one-hot digit-select bus, debounces each scan slot, decodes each segment pattern back to a hex nibble plus decimal point, and assembles a full frame. Used for driver loopback self-test and for capturing external 7-segment panels into the fabric.

Parameters:
WIDTH_NIBBLES, 6, number of digit positions; select bus width; data width is 4*WIDTH_NIBBLES.
SETTLE_CYCLES, 4, consecutive stable cycles required before a slot is captured (1..255).
IDLE_TIMEOUT, 1024, cycles with no digit selected that force frame publication (>=2).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  synchronous, active-low reset.
display_led_segments  in  8  a..g on bits 7..1, dp on bit 0; 1 = segment lit.
display_segment_enable  in  WIDTH_NIBBLES  digit select; bit i = digit i (MSB = highest nibble); 1 = active.
data  out  4*WIDTH_NIBBLES  decoded frame; nibble i from digit i.
digit_valid  out  WIDTH_NIBBLES  digit i was captured with a legal pattern in the last frame.
decimal_point  out  WIDTH_NIBBLES  dp state of each captured digit.
pattern_error  out  WIDTH_NIBBLES  digit i was captured with a pattern outside the hex table.
frame_valid  out  1  one-cycle pulse when outputs are updated.
select_error  out  1  sticky: multi-hot select seen; cleared at each frame_valid.

Behaviour:
- Reset (reset_n=0 at an edge): all outputs, shadow registers, counters and last-index cleared to 0. Reset mid-frame discards the partial frame; no frame_valid is issued for it.
- Input sampling: both buses are registered once (1-cycle input stage); all decisions use the registered values.
- Stability counter: resets to 0 whenever {segments, select} differ from the previous cycle, otherwise increments, saturating at SETTLE_CYCLES.
- Capture: occurs when the counter reaches SETTLE_CYCLES, select is exactly one-hot with index k, and this slot has not yet been captured. Capture happens once per slot; a new slot starts when select changes.
- Multi-hot select: never captured; sets select_error. All-zero select is idle, not an error.
- Decode table (segments[7:1] abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Any other pattern, including blank: nibble 0, shadow pattern_error[k]=1, shadow valid[k]=0.
  - dp = segments[0] is stored regardless.
- Frame boundary (wrap): a capture with k <= last captured index while the shadow holds at least one capture.
  - Next edge: shadow is published to the outputs and frame_valid=1.
  - In the same edge, the shadow is cleared and the current capture is written into it as the first digit of the new frame.
- Frame boundary (timeout): the idle counter counts consecutive cycles with select==0. At IDLE_TIMEOUT, with at least one shadow capture, the frame publishes as above; the counter saturates until select becomes non-zero.
- Digits not captured within a frame, e.g. blanked ones: published with nibble 0, digit_valid=0, pattern_error=0, decimal_point=0.
- Outputs hold between frames. frame_valid is never high on consecutive cycles.
- Capture latency: from the segments becoming stable at the pins to the shadow write is 1 + SETTLE_CYCLES cycles.

Decomposition:
- Shared package seven_segment_pkg:
  - segment bit positions and the 16 pattern constants, shared with the display driver;
  - the pattern-to-nibble decode function, returning {legal, nibble}.
- Sub-module seven_segment_pattern_decoder: combinational, 8-bit pattern in, {legal, nibble, dp} out.
- Top module contains the stability counter, idle counter, capture logic and shadow/output registers.

Test Plan:
- Loopback: display driver (CLK_DIVIDE=0) with data=24'h1A2B3C, digit_enable=6'h3F, dp=0 -> by the second frame_valid: data=24'h1A2B3C, digit_valid=6'h3F, pattern_error=0.
- Blanking and dp: digit_enable=6'b110111, decimal_point_enable=6'b000010 -> data=24'h1A0B3C, digit_valid=6'b110111, decimal_point=6'b000010.
- Glitch: hold digit 2 at '5', inject a 2-cycle wrong pattern, SETTLE_CYCLES=4 -> nibble 2 = 5, no error; slot captured exactly once.
- Illegal pattern: segments=8'b00000010 on digit 0 -> pattern_error[0]=1, digit_valid[0]=0, nibble 0 = 0.
- Timeout and select error: capture digits 5..3, then hold select=0 for IDLE_TIMEOUT cycles -> frame_valid pulse with digit_valid=6'b111000. Then drive select=6'b000011 -> select_error=1 until the next frame_valid.
- Reset mid-frame: pulse reset_n low after 3 captures -> all outputs 0; the next complete frame publishes correctly, with no spurious frame_valid.
